// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: widths, grant encoding, LL request payload.
package wb_arb_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned REG_AW   = 5;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_LL
    } wb_gnt_e;

    typedef struct packed {
        logic [REG_AW-1:0]   rd;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between WB stage / LL unit and the write-port arbiter, with the register-file write side.
interface wb_port_arbiter_if #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned LL_DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(LL_DEPTH) + 1;

    logic              pipe_valid;
    logic [4:0]        pipe_rd;
    logic [XLEN-1:0]   pipe_data;
    logic              pipe_stall;
    logic              ll_valid;
    logic              ll_ready;
    logic [4:0]        ll_rd;
    logic [XLEN-1:0]   ll_data;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [CNT_W-1:0]  ll_pending;

    // Arbiter side
    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
        output pipe_stall, ll_ready, rf_we, rf_waddr, rf_wdata, ll_pending
    );

    // Pipeline / LL unit / register-file side
    modport master (
        output pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
        input  pipe_stall, ll_ready, rf_we, rf_waddr, rf_wdata, ll_pending
    );

endinterface

// File: rtl/wb_port_arbiter_ll_fifo.sv
// Small synchronous FIFO holding long-latency results waiting for the write port.
module wb_ll_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  wb_req_t                      push_data_i,
    input  logic                         pop_i,
    output wb_req_t                      head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_req_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, LL results buffered, starvation forces a one-cycle stall.
// Optional WB_ARB_PERF_EN adds a saturating conflict counter output.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned LL_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb_port_arbiter_if.slave       port_if
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]            perf_conflicts_o
`endif
);
    localparam int unsigned CNT_W = $clog2(LL_DEPTH) + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_MAX) + 1;

    wb_gnt_e           gnt;
    wb_req_t           push_req;
    wb_req_t           head_req;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              starve_q, starve_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    // x0 pushes are acknowledged but never stored.
    assign fifo_push     = port_if.ll_valid && !fifo_full && (port_if.ll_rd != '0);
    assign fifo_pop      = (gnt == GNT_LL);
    assign push_req.rd   = port_if.ll_rd;
    assign push_req.data = XLEN_DEF'(port_if.ll_data);

    wb_ll_fifo #(
        .DEPTH (LL_DEPTH)
    ) u_ll_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_req),
        .pop_i       (fifo_pop),
        .head_o      (head_req),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign port_if.ll_ready   = !fifo_full;
    assign port_if.ll_pending = fifo_count;
    assign port_if.pipe_stall = starve_q;
    assign port_if.rf_we      = rf_we_q;
    assign port_if.rf_waddr   = rf_waddr_q;
    assign port_if.rf_wdata   = rf_wdata_q;

    // Grant selection, write-data mux and starvation timer.
    always_comb begin
        gnt          = GNT_NONE;
        rf_we_d      = 1'b0;
        rf_waddr_d   = '0;
        rf_wdata_d   = '0;
        starve_cnt_d = starve_cnt_q;
        starve_d     = 1'b0;

        if (starve_q && !fifo_empty) begin
            gnt = GNT_LL;
        end else if (port_if.pipe_valid && (port_if.pipe_rd != '0) && !starve_q) begin
            gnt = GNT_PIPE;
        end else if (!fifo_empty) begin
            gnt = GNT_LL;
        end

        case (gnt)
            GNT_PIPE: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = port_if.pipe_rd;
                rf_wdata_d = port_if.pipe_data;
            end
            GNT_LL: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = head_req.rd;
                rf_wdata_d = XLEN'(head_req.data);
            end
            default: ;
        endcase

        if (fifo_empty || (gnt == GNT_LL)) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SC_W'(STARVE_MAX - 1)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end

        starve_d = !starve_q && !fifo_empty && (gnt != GNT_LL) &&
                   (starve_cnt_q == SC_W'(STARVE_MAX - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_conflicts_q;

    assign perf_conflicts_o = perf_conflicts_q;

    // Cycles where a buffered LL result lost the port to the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflicts_q <= '0;
        end else if (!fifo_empty && (gnt == GNT_PIPE) && (perf_conflicts_q != '1)) begin
            perf_conflicts_q <= perf_conflicts_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (also exercises WB_ARB_PERF_EN when defined).
module tb_wb_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   stall_cnt;
    int   ll_seen;
    logic prev_stall;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_conflicts;
`endif

    wb_port_arbiter_if #(.XLEN(64), .LL_DEPTH(2)) bus ();

    wb_port_arbiter #(
        .XLEN       (64),
        .LL_DEPTH   (2),
        .STARVE_MAX (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .port_if          (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_conflicts_o (perf_conflicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_valid = 1'b0;
        bus.pipe_rd    = 5'd0;
        bus.pipe_data  = 64'd0;
        bus.ll_valid   = 1'b0;
        bus.ll_rd      = 5'd0;
        bus.ll_data    = 64'd0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rf_we",   64'(bus.rf_we), 64'd0);
        check("rst_pending", 64'(bus.ll_pending), 64'd0);
        check("rst_ready",   64'(bus.ll_ready), 64'd1);
        check("rst_stall",   64'(bus.pipe_stall), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1) async reset in the middle of traffic
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 64'h1;
        bus.ll_valid   = 1'b1; bus.ll_rd   = 5'd2; bus.ll_data   = 64'h2;
        cyc();
        check("t1_pre_we",      64'(bus.rf_we), 64'd1);
        check("t1_pre_pending", 64'(bus.ll_pending), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t1_rf_we",   64'(bus.rf_we), 64'd0);
        check("t1_pending", 64'(bus.ll_pending), 64'd0);
        check("t1_ready",   64'(bus.ll_ready), 64'd1);
        check("t1_stall",   64'(bus.pipe_stall), 64'd0);
        idle();
        cyc();
        rst_n = 1'b1;
        cyc();

        // 2) pipe-only write, then a write to x0
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 64'hA5;
        cyc();
        check("t2_we",    64'(bus.rf_we), 64'd1);
        check("t2_waddr", 64'(bus.rf_waddr), 64'd5);
        check("t2_wdata", bus.rf_wdata, 64'hA5);
        bus.pipe_rd = 5'd0; bus.pipe_data = 64'hFF;
        cyc();
        check("t2_x0_we", 64'(bus.rf_we), 64'd0);
        idle();
        cyc();

        // 3) LL push with idle pipe: stored, written the next cycle
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd7; bus.ll_data = 64'h1234;
        cyc();
        check("t3_pending", 64'(bus.ll_pending), 64'd1);
        check("t3_no_bypass", 64'(bus.rf_we), 64'd0);
        idle();
        cyc();
        check("t3_we",      64'(bus.rf_we), 64'd1);
        check("t3_waddr",   64'(bus.rf_waddr), 64'd7);
        check("t3_wdata",   bus.rf_wdata, 64'h1234);
        check("t3_empty",   64'(bus.ll_pending), 64'd0);
        cyc();
        check("t3_idle_we", 64'(bus.rf_we), 64'd0);

        // 4) continuous pipe traffic starves one LL result -> single forced stall
        stall_cnt  = 0;
        ll_seen    = 0;
        prev_stall = 1'b0;
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_data = 64'h900;
        bus.ll_valid   = 1'b1; bus.ll_rd   = 5'd11; bus.ll_data  = 64'hBEEF;
        for (int i = 0; i < 12; i++) begin
            cyc();
            bus.ll_valid = 1'b0;
            if (bus.rf_we && (bus.rf_waddr == 5'd11)) begin
                ll_seen++;
                check("t4_ll_data", bus.rf_wdata, 64'hBEEF);
                check("t4_after_stall", 64'(prev_stall), 64'd1);
            end
            prev_stall = bus.pipe_stall;
            if (bus.pipe_stall) stall_cnt++;
        end
        check("t4_stall_cycles", 64'(stall_cnt), 64'd1);
        check("t4_ll_writes",    64'(ll_seen), 64'd1);
        check("t4_empty",        64'(bus.ll_pending), 64'd0);
        idle();
        cyc();

        // 5) fill under a busy pipe, third offer refused, FIFO-order drain
        reset_pulse();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 64'h10;
        bus.ll_valid   = 1'b1; bus.ll_rd   = 5'd3; bus.ll_data   = 64'h33;
        cyc();
        check("t5_pend1",  64'(bus.ll_pending), 64'd1);
        check("t5_ready1", 64'(bus.ll_ready), 64'd1);
        bus.ll_rd = 5'd4; bus.ll_data = 64'h44;
        cyc();
        check("t5_pend2",  64'(bus.ll_pending), 64'd2);
        check("t5_full",   64'(bus.ll_ready), 64'd0);
        bus.ll_rd = 5'd5; bus.ll_data = 64'h55;
        cyc();
        check("t5_held",   64'(bus.ll_pending), 64'd2);
        check("t5_pipe_w", 64'(bus.rf_waddr), 64'd1);
        check("t5_nostall", 64'(bus.pipe_stall), 64'd0);
        idle();
        cyc();
        check("t5_d1_addr", 64'(bus.rf_waddr), 64'd3);
        check("t5_d1_data", bus.rf_wdata, 64'h33);
        check("t5_d1_pend", 64'(bus.ll_pending), 64'd1);
        cyc();
        check("t5_d2_addr", 64'(bus.rf_waddr), 64'd4);
        check("t5_d2_data", bus.rf_wdata, 64'h44);
        check("t5_d2_pend", 64'(bus.ll_pending), 64'd0);
        cyc();
        check("t5_done_we", 64'(bus.rf_we), 64'd0);
`ifdef WB_ARB_PERF_EN
        check("t5_perf", 64'(perf_conflicts), 64'd2);
`endif

        // 6) LL push to x0 is accepted and discarded
        bus.ll_valid = 1'b1; bus.ll_rd = 5'd0; bus.ll_data = 64'h77;
        #1;
        check("t6_ready",   64'(bus.ll_ready), 64'd1);
        cyc();
        check("t6_pending", 64'(bus.ll_pending), 64'd0);
        idle();
        cyc();
        check("t6_no_we",   64'(bus.rf_we), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
